// File: rtl/arithm_pkg.sv
// Shared arithmetic definitions: width helper, accumulator FSM states, default widths.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package arithm_pkg;

  // Default accumulator width for the dot-product stage.
  localparam int ACC_DEFAULT_WIDTH = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Smallest r such that 2**r >= value; used to size count/length fields.
  function automatic int log2ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_add_param.sv
// Unsigned ACC_WIDTH adder returning sum and carry-out; optional clamp (DROMOS_ACC_SATURATE_EN).
// Latency: purely combinational.
// Backpressure: none, no handshake.
module acc_add_param
  import arithm_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_DEFAULT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);

  logic [ACC_WIDTH:0] full;

  // One extra bit captures the carry; with saturation the sum pins at all-ones,
  // and since any further non-zero addend carries again it stays pinned.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[ACC_WIDTH];
`ifdef DROMOS_ACC_SATURATE_EN
    sum   = carry ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
    sum   = full[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a run of LEN unsigned products into one sum; saturating build via DROMOS_ACC_SATURATE_EN.
// Latency: result valid the cycle after the last accepted beat; one product per cycle in ACCUM.
// Backpressure: in_ready only high in ACCUM; result/overflow held while out_valid & !out_ready.
module product_accumulator
  import arithm_pkg::*;
#(
  parameter int WIDTH_P   = 32,
  parameter int ACC_WIDTH = ACC_DEFAULT_WIDTH,  // must be >= WIDTH_P
  parameter int MAX_LEN   = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [log2ceil(MAX_LEN+1)-1:0]    len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH_P-1:0]                in_product,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH-1:0]              result,
  output logic                              overflow,
  output logic                              busy
);

  localparam int               LEN_W     = log2ceil(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_V     = LEN_W'(1);

  acc_state_t           state;
  acc_state_t           next_state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] result_q;
  logic                 ovf_q;
  logic [LEN_W-1:0]     count;
  logic [LEN_W-1:0]     len_clamped;
  logic                 beat;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;

  // Beat is derived from state directly so in_ready never feeds back into the FSM.
  assign beat        = in_valid && (state == ACCUM);
  assign last_beat   = beat && (count == ONE_V);
  assign len_clamped = (len > MAX_LEN_V) ? MAX_LEN_V : len;
  assign result      = result_q;
  assign overflow    = ovf_q;

  acc_add_param #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .a     (acc),
    .b     (ACC_WIDTH'(in_product)),
    .sum   (sum),
    .carry (carry)
  );

  // State register; reset aborts any run without emitting a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; start only matters in IDLE.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: run setup in IDLE, accumulate/count per beat, capture final sum on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= len_clamped;
            ovf_q <= 1'b0;
            if (len == '0) begin
              result_q <= '0;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= sum;
            count <= count - ONE_V;
            ovf_q <= ovf_q | carry;
            if (last_beat) begin
              result_q <= sum;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (32-bit product, 32-bit accumulator, MAX_LEN=8).
// Latency: expects out_valid one cycle after the last beat.
// Backpressure: exercises out_ready stalls in DONE and input gaps in ACCUM.
module tb_product_accumulator;

  localparam int WP = 32;
  localparam int AW = 32;
  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WP-1:0] in_product = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] result;
  logic          overflow;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;
  logic [AW:0]   sb_q[$];
  logic [WP-1:0] p[$];

  always #5 clk = ~clk;

  product_accumulator #(
    .WIDTH_P   (WP),
    .ACC_WIDTH (AW),
    .MAX_LEN   (ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference sum {overflow, result} over the first n products.
  function automatic logic [AW:0] model(input int n, input logic [WP-1:0] q[$]);
    logic [AW-1:0] a;
    logic          ov;
    logic [AW:0]   s;
    a  = '0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, a} + (AW+1)'(q[i]);
      if (s[AW]) begin
        ov = 1'b1;
`ifdef DROMOS_ACC_SATURATE_EN
        a = {AW{1'b1}};
`else
        a = s[AW-1:0];
`endif
      end else begin
        a = s[AW-1:0];
      end
    end
    return {ov, a};
  endfunction

  // Result monitor: every completed handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_pending", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        logic [AW:0] e;
        e = sb_q.pop_front();
        chk("result", result, e[AW-1:0]);
        chk("overflow", overflow, e[AW]);
      end
    end
  end

  // Start a run and feed products; optional idle cycle between beats.
  task automatic drive_run(input int n_len, input logic [WP-1:0] q[$], input bit gaps);
    int n;
    n = (n_len > ML) ? ML : n_len;
    @(posedge clk); #1;
    start = 1'b1;
    len   = LW'(n_len);
    sb_q.push_back(model(n, q));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      in_product = q[i];
      chk("in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_product = 32'hDEAD_BEEF;
      if (gaps && i != n - 1) begin
        chk("gap_busy", busy, 1);
        @(posedge clk); #1;
      end
    end
    chk("out_valid_lat", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk); #1;
    chk(tag, busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_result", result, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Basic back-to-back run
    p.delete();
    p.push_back(32'd10); p.push_back(32'd20); p.push_back(32'd30); p.push_back(32'd40);
    drive_run(4, p, 1'b0);
    expect_idle("idle_basic");

    // Input stalls between beats
    p.delete();
    p.push_back(32'd5); p.push_back(32'd7); p.push_back(32'd9);
    drive_run(3, p, 1'b1);
    expect_idle("idle_stall");

    // Output backpressure with ignored start pulses
    out_ready = 1'b0;
    p.delete();
    p.push_back(32'd3); p.push_back(32'd4);
    drive_run(2, p, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 7);
      chk("bp_in_ready", in_ready, 0);
      start = 1'b1;
      len   = 4'd1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bp_idle", busy, 0);

    // Empty run
    p.delete();
    drive_run(0, p, 1'b0);
    expect_idle("idle_empty");

    // Overflow on carry-out
    p.delete();
    p.push_back(32'hFFFF_FFFF); p.push_back(32'h2);
    drive_run(2, p, 1'b0);
    expect_idle("idle_ovf");

    // Overflow cleared at next run start
    p.delete();
    p.push_back(32'd1); p.push_back(32'd2);
    drive_run(2, p, 1'b0);
    expect_idle("idle_clear");

    // len above MAX_LEN clamps to MAX_LEN beats
    p.delete();
    for (int i = 1; i <= ML; i++) p.push_back(WP'(i));
    drive_run(15, p, 1'b0);
    expect_idle("idle_clamp");

    // Reset mid-run aborts without a result
    @(posedge clk); #1;
    start = 1'b1;
    len   = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid   = 1'b1;
      in_product = 32'd100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p.delete();
    p.push_back(32'd7);
    drive_run(1, p, 1'b0);
    expect_idle("idle_after_abort");

    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule
